// File: rtl/rat_io_pkg.sv
// Shared RAT MCU I/O definitions: port IDs, UART transmitter state encoding
// and status byte bit positions.
package rat_io_pkg;

  localparam logic [7:0] PORT_SWITCHES    = 8'h20;
  localparam logic [7:0] PORT_LEDS        = 8'h40;
  localparam logic [7:0] PORT_KEYPAD      = 8'h80;
  localparam logic [7:0] PORT_SEVSEG      = 8'h81;
  localparam logic [7:0] PORT_SPEAKER     = 8'h82;
  localparam logic [7:0] PORT_UART_DATA   = 8'h83;
  localparam logic [7:0] PORT_UART_STATUS = 8'h84;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 7;

  // Rounded clocks-per-bit; below 4 the frame timing degenerates.
  function automatic int calc_div(input int clk_freq, input int baud);
    int d;
    d = (clk_freq + baud / 2) / baud;
    return (d < 4) ? 4 : d;
  endfunction

endpackage

// File: rtl/rat_uart_tx_port_if.sv
// CPU I/O bus as seen by a RAT port-mapped peripheral.
interface rat_uart_tx_port_if;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] IN_DATA;

  modport master (output PORT_ID, output OUT_PORT, output IO_STRB, input IN_DATA);
  modport slave  (input PORT_ID, input OUT_PORT, input IO_STRB, output IN_DATA);
endinterface

// File: rtl/rat_sync_fifo.sv
// Single-clock FIFO with wrapping pointers and occupancy count. Callers must
// not push when full or pop when empty.
module rat_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/rat_uart_tx_port.sv
// Port-mapped 8N1 UART transmitter for the RAT I/O bus with a byte FIFO.
// Define RAT_UART_TX_IRQ_EN to enable the one-cycle completion INTERRUPT.
//
// state    | meaning
// TX_IDLE  | line high, waiting for FIFO data
// TX_START | start bit (low) for DIV cycles
// TX_DATA  | eight data bits, LSB first, DIV cycles each
// TX_STOP  | stop bit (high), then next frame or idle
module rat_uart_tx_port
  import rat_io_pkg::*;
#(
  parameter int         CLK_FREQ       = 100_000_000,
  parameter int         BAUD           = 115200,
  parameter logic [7:0] DATA_PORT_ID   = PORT_UART_DATA,
  parameter logic [7:0] STATUS_PORT_ID = PORT_UART_STATUS,
  parameter int         FIFO_DEPTH     = 8
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  rat_uart_tx_port_if.slave        bus,
  output logic                     TX,
  output logic                     INTERRUPT
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] BAUD_LOAD = CW'(DIV - 1);

  tx_state_t                     state;
  logic [CW-1:0]                 baud_cnt;
  logic [2:0]                    bit_idx;
  logic [7:0]                    shift;
  logic                          strb_q;
  logic                          ovf;
  logic                          wr_evt;
  logic                          data_wr;
  logic                          stat_wr;
  logic                          fifo_push;
  logic                          fifo_pop;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          has_data;
  logic                          bit_end;
  logic [7:0]                    fifo_dout;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic [7:0]                    status;

  // The CPU strobe spans several CLK cycles; act only on its rising edge.
  assign wr_evt  = bus.IO_STRB & ~strb_q;
  assign data_wr = wr_evt & (bus.PORT_ID == DATA_PORT_ID);
  assign stat_wr = wr_evt & (bus.PORT_ID == STATUS_PORT_ID);

  assign fifo_push = data_wr & ~fifo_full;
  assign has_data  = (fifo_count != '0);
  assign bit_end   = (baud_cnt == '0);
  assign fifo_pop  = has_data & ((state == TX_IDLE) | ((state == TX_STOP) & bit_end));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      strb_q <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      strb_q <= bus.IO_STRB;
      if (data_wr && fifo_full)
        ovf <= 1'b1;
      else if (stat_wr && bus.OUT_PORT[7])
        ovf <= 1'b0;
    end
  end

  rat_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET_N),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (bus.OUT_PORT),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef RAT_UART_TX_IRQ_EN
  logic irq;
  assign INTERRUPT = irq;
`else
  assign INTERRUPT = 1'b0;
`endif

  // TX is registered from the current state, so the line trails the FSM by one cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      TX       <= 1'b1;
`ifdef RAT_UART_TX_IRQ_EN
      irq      <= 1'b0;
`endif
    end else begin
      case (state)
        TX_START: TX <= 1'b0;
        TX_DATA:  TX <= shift[0];
        default:  TX <= 1'b1;
      endcase
`ifdef RAT_UART_TX_IRQ_EN
      irq <= 1'b0;
`endif
      case (state)
        TX_IDLE: begin
          if (has_data) begin
            shift    <= fifo_dout;
            baud_cnt <= BAUD_LOAD;
            state    <= TX_START;
          end
        end
        TX_START: begin
          if (bit_end) begin
            baud_cnt <= BAUD_LOAD;
            bit_idx  <= '0;
            state    <= TX_DATA;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            baud_cnt <= BAUD_LOAD;
            shift    <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7)
              state <= TX_STOP;
            else
              bit_idx <= bit_idx + 1'b1;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            if (has_data) begin
              shift    <= fifo_dout;
              baud_cnt <= BAUD_LOAD;
              state    <= TX_START;
            end else begin
              state <= TX_IDLE;
`ifdef RAT_UART_TX_IRQ_EN
              irq   <= 1'b1;
`endif
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  always_comb begin
    status             = 8'h00;
    status[STAT_FULL]  = fifo_full;
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_BUSY]  = (state != TX_IDLE);
    status[STAT_OVF]   = ovf;
  end

  assign bus.IN_DATA = (bus.PORT_ID == STATUS_PORT_ID) ? status : 8'h00;

endmodule

// File: tb/tb_rat_uart_tx_port.sv
// Scoreboard bench for rat_uart_tx_port: a line monitor decodes TX frames and
// compares each byte with the queue filled by the stimulus.
module tb_rat_uart_tx_port;

  localparam int DIV = 10;
`ifdef RAT_UART_TX_IRQ_EN
  localparam int IRQ_PER_BURST = 1;
`else
  localparam int IRQ_PER_BURST = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx;
  logic irq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int irq_cnt = 0;
  int irq_cyc = 0;
  int frames = 0;
  int accept_cyc = 0;
  bit frame_rst = 1'b0;

  logic [7:0] exp_q[$];
  int         starts[$];

  rat_uart_tx_port_if bus ();

  rat_uart_tx_port #(
    .CLK_FREQ (1000),
    .BAUD     (100)
  ) dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .bus       (bus),
    .TX        (tx),
    .INTERRUPT (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (irq === 1'b1) begin irq_cnt++; irq_cyc = cyc; end
  always @(negedge rst_n) frame_rst = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Line monitor: each frame must hold every bit constant for exactly DIV cycles.
  initial begin : monitor
    logic       tx_prev;
    logic [9:0] bits;
    bit         stable;
    logic [7:0] e;
    tx_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && tx_prev === 1'b1 && tx === 1'b0) begin
        frame_rst = 1'b0;
        starts.push_back(cyc);
        stable = 1'b1;
        for (int b = 0; b < 10; b++) begin
          for (int k = 0; k < DIV; k++) begin
            if (!(b == 0 && k == 0)) @(negedge clk);
            if (k == 0) bits[b] = tx;
            else if (tx !== bits[b]) stable = 1'b0;
          end
        end
        tx_prev = tx;
        if (!frame_rst) begin
          frames++;
          chk("frame_start_bit", {31'd0, bits[0]}, 32'd0);
          chk("frame_stop_bit", {31'd0, bits[9]}, 32'd1);
          chk("frame_bit_timing", {31'd0, stable}, 32'd1);
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", {24'd0, bits[8:1]}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("frame_byte", {24'd0, bits[8:1]}, {24'd0, e});
          end
        end
      end else begin
        tx_prev = tx;
      end
    end
  end

  task automatic bus_write(input logic [7:0] id, input logic [7:0] data, input int hold);
    @(negedge clk);
    bus.PORT_ID  = id;
    bus.OUT_PORT = data;
    bus.IO_STRB  = 1'b1;
    @(negedge clk);
    accept_cyc = cyc;
    repeat (hold - 1) @(negedge clk);
    bus.IO_STRB = 1'b0;
  endtask

  task automatic read_port(input logic [7:0] id, output logic [7:0] v);
    bus.PORT_ID = id;
    #1 v = bus.IN_DATA;
  endtask

  initial begin : stim
    logic [7:0] st;
    int s0, f0, i0, a0;
    bus.PORT_ID  = 8'h00;
    bus.OUT_PORT = 8'h00;
    bus.IO_STRB  = 1'b0;

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    read_port(8'h84, st);
    chk("reset_status", {24'd0, st}, 32'h02);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 0x55 with a 5-cycle strobe
    s0 = starts.size();
    f0 = frames;
    i0 = irq_cnt;
    exp_q.push_back(8'h55);
    bus_write(8'h83, 8'h55, 5);
    a0 = accept_cyc;
    repeat (130) @(negedge clk);
    chk("s1_frames", frames - f0, 1);
    chk("s1_queue_drained", exp_q.size(), 0);
    if (starts.size() > s0) chk("s1_start_latency", starts[s0] - a0, 2);
    else chk("s1_start_latency", 32'hFFFF_FFFF, 2);
    chk("s1_irq_count", irq_cnt - i0, IRQ_PER_BURST);
`ifdef RAT_UART_TX_IRQ_EN
    if (starts.size() > s0) chk("s1_irq_time", irq_cyc - starts[s0], 99);
`endif
    read_port(8'h84, st);
    chk("s1_status_idle", {24'd0, st}, 32'h02);

    // Long strobe gives exactly one frame
    f0 = frames;
    exp_q.push_back(8'hA3);
    bus_write(8'h83, 8'hA3, 6);
    repeat (130) @(negedge clk);
    chk("s2_frames", frames - f0, 1);
    chk("s2_queue_drained", exp_q.size(), 0);

    // Overflow while busy, back-to-back frames, ovf clear
    s0 = starts.size();
    f0 = frames;
    i0 = irq_cnt;
    exp_q.push_back(8'hC3);
    bus_write(8'h83, 8'hC3, 2);
    repeat (3) @(negedge clk);
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_q.push_back(8'(i));
      bus_write(8'h83, 8'(i), 2);
    end
    @(negedge clk);
    read_port(8'h84, st);
    chk("s3_status_full_ovf", {24'd0, st}, 32'h85);
    bus_write(8'h84, 8'h80, 2);
    @(negedge clk);
    read_port(8'h84, st);
    chk("s3_status_ovf_cleared", {24'd0, st}, 32'h05);
    repeat (1000) @(negedge clk);
    chk("s3_frames", frames - f0, 9);
    chk("s3_queue_drained", exp_q.size(), 0);
    for (int k = 0; k < 8; k++) begin
      if (starts.size() > s0 + k + 1)
        chk("s3_b2b_spacing", starts[s0+k+1] - starts[s0+k], 10 * DIV);
      else
        chk("s3_b2b_spacing", 32'hFFFF_FFFF, 10 * DIV);
    end
    chk("s3_irq_count", irq_cnt - i0, IRQ_PER_BURST);
    read_port(8'h84, st);
    chk("s3_status_idle", {24'd0, st}, 32'h02);

    // Reset in the middle of data bit 4 of 0xF0
    f0 = frames;
    i0 = irq_cnt;
    bus_write(8'h83, 8'hF0, 2);
    a0 = accept_cyc;
    while (cyc < a0 + 57) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("s4_tx_high_in_reset", {31'd0, tx}, 32'd1);
    read_port(8'h84, st);
    chk("s4_status_in_reset", {24'd0, st}, 32'h02);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    chk("s4_no_irq", irq_cnt - i0, 0);
    chk("s4_no_frame", frames - f0, 0);
    chk("s4_tx_idle", {31'd0, tx}, 32'd1);
    read_port(8'h84, st);
    chk("s4_status_after", {24'd0, st}, 32'h02);

    // Foreign port IDs
    s0 = starts.size();
    bus_write(8'h40, 8'h77, 2);
    read_port(8'h20, st);
    chk("s5_in_data_other_port", {24'd0, st}, 32'h00);
    read_port(8'h83, st);
    chk("s5_in_data_data_port", {24'd0, st}, 32'h00);
    repeat (30) @(negedge clk);
    chk("s5_no_start", starts.size() - s0, 0);
    chk("s5_tx_idle", {31'd0, tx}, 32'd1);
    read_port(8'h84, st);
    chk("s5_status", {24'd0, st}, 32'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rat_uart_tx_port.md
# rat_uart_tx_port

Port-mapped UART transmitter peripheral for the RAT MCU I/O bus. It accepts bytes written by the CPU to a data port ID, buffers them in a small FIFO, and serialises each byte as 8N1 on a single TX pin. It exposes a status byte for CPU reads and an optional completion interrupt. It instantiates beside the keypad, seven-segment and speaker peripherals in the board wrapper, which ORs/muxes its read data into the CPU input port.

## Interface
Parameters:
- CLK_FREQ, 100_000_000 — CLK frequency in Hz.
- BAUD, 115200 — line rate; DIV = round(CLK_FREQ/BAUD), minimum 4.
- DATA_PORT_ID, 8'h83 — OUT writes to this ID push a byte.
- STATUS_PORT_ID, 8'h84 — IN reads of this ID return status; OUT writes to it clear flags.
- FIFO_DEPTH, 8 — power of two, 2..64.

Ports:
- CLK  in  1  board clock; the block operates on posedge CLK only.
- RESET_N  in  1  asynchronous, active-low reset.
- PORT_ID  in  8  CPU port ID.
- OUT_PORT  in  8  CPU write data.
- IO_STRB  in  1  CPU write strobe (CPU-clock domain; may be high ≥2 CLK cycles).
- IN_DATA  out  8  status byte; 8'h00 when PORT_ID ≠ STATUS_PORT_ID.
- TX  out  1  serial line; idles high.
- INTERRUPT  out  1  one-CLK completion pulse.

## Operation
- Write detect: registered strb_q; wr_evt = IO_STRB & ~strb_q. One event per strobe regardless of strobe length.
- Data write: wr_evt & PORT_ID==DATA_PORT_ID. If FIFO not full, push OUT_PORT. If full, drop the byte and set ovf (sticky). A simultaneous pop does not rescue the write.
- Status write: wr_evt & PORT_ID==STATUS_PORT_ID & OUT_PORT[7] clears ovf. Other bits are ignored.
- Status byte (combinational from registers): [0] full, [1] empty, [2] busy (FSM ≠ IDLE), [6:3] 0, [7] ovf.
- FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: TX=1. If FIFO is not empty, pop into shift register, load baud counter, go to START.
  - START: TX=0 for DIV cycles → DATA, bit index 0.
  - DATA: TX=shift[0] for DIV cycles, shift right, index+1. After index 7 → STOP.
  - STOP: TX=1 for DIV cycles. Then, if FIFO is not empty, pop and go directly to START (back-to-back frames, no idle gap). Otherwise go to IDLE and pulse INTERRUPT.
- Baud counter counts DIV-1 down to 0. A bit period ends at 0.
- FIFO: wrapping read/write pointers plus occupancy count of width clog2(FIFO_DEPTH)+1. Push and pop in the same cycle leave the count unchanged.
- Reset (any time, including mid-frame): FSM=IDLE, TX=1, FIFO empty, ovf=0, strb_q=0, INTERRUPT=0. IN_DATA reflects the reset state (8'h02 when status is selected). A partial frame is abandoned; TX returns high immediately.

## Timing
- Accepted write into an empty FIFO in IDLE: count=1 at edge N, pop at edge N+1, TX falls at edge N+2.
- Frame length is exactly 10×DIV cycles. Back-to-back frames give a stop bit of DIV cycles and then the next start bit.
- INTERRUPT is high for exactly one cycle, at the edge where STOP ends with the FIFO empty.
- Status bits are valid one cycle after the causing edge. IN_DATA is combinational on PORT_ID.

## Configuration
- RAT_UART_TX_IRQ_EN defined: INTERRUPT behaves as above.
- Not defined: INTERRUPT is tied 1'b0 and its generation logic is absent. All other behaviour is unchanged.

## Structure
- Shared package rat_io_pkg holds the port ID localparams (SWITCHES 8'h20, LEDS 8'h40, KEYPAD 8'h80, SEVSEG 8'h81, SPEAKER 8'h82, UART_DATA 8'h83, UART_STATUS 8'h84), the tx_state_t enum, and the status bit index constants.
- One sub-module: rat_sync_fifo (parameterised width/depth; push, pop, full, empty, count).

## Test plan
Bench uses CLK_FREQ=1000, BAUD=100, so DIV=10.
- Reset then idle: TX=1, INTERRUPT=0, IN_DATA=8'h02 with PORT_ID=8'h84. After a 5-cycle strobe to 8'h83 with data 0x55, TX falls two edges after acceptance and then reads 0,1,0,1,0,1,0,1,0,1 at 10 cycles per bit, followed by a one-cycle INTERRUPT.
- Strobe held 6 CLK cycles to 8'h83 with 0xA3: exactly one frame is sent (count reaches 1, never 2).
- Nine writes (0x01..0x09) while busy with FIFO_DEPTH 8: frames appear back-to-back with no gap, one byte is dropped, status[7]=1. Writing 8'h80 to 8'h84 clears status[7].
- Assert RESET_N low mid DATA bit 4 of 0xF0: TX goes 1 immediately, status reads 8'h02, and no INTERRUPT pulse occurs.
- Write to 8'h40 and read 8'h20: no push, IN_DATA=8'h00, TX stays 1.
- Build without RAT_UART_TX_IRQ_EN: repeat the first scenario; INTERRUPT stays 0 and the TX waveform is identical.
